// File: rtl/buzzer_tone_gen.sv
// Square-wave / pass-through buzzer driver with glitch-free edges and a max-on watchdog.
// Outputs are registered from the next-state values, so every pin change lags its cause by one cycle.
module buzzer_tone_gen #(
    parameter int HP_W          = 16,
    parameter int MAX_ON_W      = 32,
    parameter int MAX_ON_CYCLES = 0
) (
    input  logic            aclk,
    input  logic            reset,
    input  logic            gate_in,
    input  logic            tone_en,
    input  logic [HP_W-1:0] half_period,
    output logic            BUZZER_OUT,
    output logic            tone_busy,
    output logic            timeout_flag
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, LOCKOUT} state_t;

    localparam logic [HP_W-1:0]   HP_ONE   = 1;
    localparam logic [MAX_ON_W:0] WON_ONE  = 1;
    localparam logic [MAX_ON_W:0] WD_LIMIT = (MAX_ON_W+1)'(MAX_ON_CYCLES);
    localparam bit                WD_EN    = (MAX_ON_CYCLES > 0);

    state_t              state, state_n;
    logic                phase, phase_n;
    logic                mode_s, mode_s_n;
    logic                to_mark, to_mark_n;
    logic [HP_W-1:0]     cnt, cnt_n;
    logic [HP_W-1:0]     hp_s, hp_s_n;
    logic [HP_W-1:0]     hp_in;
    logic [MAX_ON_W-1:0] won, won_n;
    logic                last, expire;
    logic                buzz_n, busy_n, flag_n;

    // Saturating increment: the watchdog count never wraps past its limit.
    function automatic logic [MAX_ON_W-1:0] sat_inc(input logic [MAX_ON_W-1:0] v);
        logic [MAX_ON_W:0] s;
        s = {1'b0, v} + WON_ONE;
        if (s >= WD_LIMIT)
            return WD_LIMIT[MAX_ON_W-1:0];
        return s[MAX_ON_W-1:0];
    endfunction

    assign hp_in  = (half_period == '0) ? HP_ONE : half_period;
    assign last   = (cnt == hp_s - HP_ONE);
    assign expire = WD_EN && (({1'b0, won} + WON_ONE) >= WD_LIMIT);

    always_comb begin
        state_n   = state;
        phase_n   = phase;
        cnt_n     = cnt;
        hp_s_n    = hp_s;
        mode_s_n  = mode_s;
        won_n     = won;
        to_mark_n = to_mark;

        case (state)
            IDLE: begin
                won_n     = '0;
                to_mark_n = 1'b0;
                phase_n   = 1'b0;
                cnt_n     = '0;
                if (gate_in) begin
                    state_n  = RUN;
                    phase_n  = 1'b1;
                    hp_s_n   = hp_in;
                    mode_s_n = tone_en;
                end
            end
            RUN: begin
                won_n = sat_inc(won);
                if (last) begin
                    cnt_n   = '0;
                    phase_n = ~phase;
                    // New half-period is adopted only where a fresh high half starts.
                    if (!phase)
                        hp_s_n = hp_in;
                end else begin
                    cnt_n = cnt + HP_ONE;
                end
                if (!gate_in) begin
                    if (!mode_s || !phase || last) begin
                        state_n = IDLE;
                        phase_n = 1'b0;
                        cnt_n   = '0;
                    end else begin
                        state_n = DRAIN;
                    end
                end else if (expire) begin
                    if (mode_s && phase && !last) begin
                        state_n   = DRAIN;
                        to_mark_n = 1'b1;
                    end else begin
                        state_n = LOCKOUT;
                        phase_n = 1'b0;
                        cnt_n   = '0;
                    end
                end
            end
            DRAIN: begin
                if (last) begin
                    state_n   = to_mark ? LOCKOUT : IDLE;
                    phase_n   = 1'b0;
                    cnt_n     = '0;
                    to_mark_n = 1'b0;
                end else begin
                    cnt_n = cnt + HP_ONE;
                end
            end
            LOCKOUT: begin
                phase_n = 1'b0;
                cnt_n   = '0;
                if (!gate_in)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n == RUN) || (state_n == DRAIN);
        flag_n = (state_n == LOCKOUT);
        buzz_n = ((state_n == RUN) && (mode_s_n ? phase_n : 1'b1)) || (state_n == DRAIN);
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state        <= IDLE;
            phase        <= 1'b0;
            cnt          <= '0;
            mode_s       <= 1'b0;
            won          <= '0;
            to_mark      <= 1'b0;
            BUZZER_OUT   <= 1'b0;
            tone_busy    <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            state        <= state_n;
            phase        <= phase_n;
            cnt          <= cnt_n;
            mode_s       <= mode_s_n;
            won          <= won_n;
            to_mark      <= to_mark_n;
            BUZZER_OUT   <= buzz_n;
            tone_busy    <= busy_n;
            timeout_flag <= flag_n;
        end
        hp_s <= hp_s_n;
    end

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Bench for buzzer_tone_gen: two instances (watchdog off / 20 cycles) checked every cycle
// against a half-length countdown model, plus hand-computed pulse counts for each scenario.
module tb_buzzer_tone_gen;

    logic        clk = 1'b0;
    logic        reset, gate, ten;
    logic [15:0] hp;
    logic        buz0, busy0, flag0, buz1, busy1, flag1;
    int          errors = 0;
    int          checks = 0;
    bit          mvalid = 1'b0;

    always #5 clk = ~clk;

    buzzer_tone_gen #(.HP_W(16), .MAX_ON_W(32), .MAX_ON_CYCLES(0)) dut0 (
        .aclk(clk), .reset(reset), .gate_in(gate), .tone_en(ten), .half_period(hp),
        .BUZZER_OUT(buz0), .tone_busy(busy0), .timeout_flag(flag0));

    buzzer_tone_gen #(.HP_W(16), .MAX_ON_W(32), .MAX_ON_CYCLES(20)) dut1 (
        .aclk(clk), .reset(reset), .gate_in(gate), .tone_en(ten), .half_period(hp),
        .BUZZER_OUT(buz1), .tone_busy(busy1), .timeout_flag(flag1));

    // st: 0 idle, 1 run, 2 drain, 3 lockout. left = cycles still to show in the current half.
    typedef struct {
        int st;
        bit lvl;
        int left;
        int hp;
        bit tone;
        int on;
        bit tmo;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t mstep(mdl_t m, bit rst, bit g, bit te, int hpin, int maxon);
        mdl_t n;
        bit   done;
        int   hpe;
        n    = m;
        done = 1'b0;
        hpe  = (hpin == 0) ? 1 : hpin;
        if (rst) begin
            n = '{0, 0, 0, 1, 0, 0, 0};
            return n;
        end
        case (m.st)
            0: if (g) n = '{1, 1, hpe, hpe, te, 0, 0};
            1: begin
                n.on   = m.on + 1;
                n.left = m.left - 1;
                done   = (n.left == 0);
                if (done) begin
                    n.lvl = !m.lvl;
                    if (n.lvl) n.hp = hpe;
                    n.left = n.hp;
                end
                if (!g) begin
                    if (!m.tone || !m.lvl || done) n.st = 0;
                    else n.st = 2;
                end else if (maxon > 0 && n.on >= maxon) begin
                    if (m.tone && m.lvl && !done) begin
                        n.st  = 2;
                        n.tmo = 1'b1;
                    end else begin
                        n.st = 3;
                    end
                end
            end
            2: begin
                n.left = m.left - 1;
                if (n.left == 0) n.st = m.tmo ? 3 : 0;
            end
            3: if (!g) n.st = 0;
            default: n.st = 0;
        endcase
        return n;
    endfunction

    function automatic int e_buz(mdl_t m);
        return (((m.st == 1) && (m.tone ? m.lvl : 1'b1)) || (m.st == 2)) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m0     <= mstep(m0, reset, gate, ten, int'(hp), 0);
        m1     <= mstep(m1, reset, gate, ten, int'(hp), 20);
        mvalid <= 1'b1;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("dut0_buzzer", int'(buz0), e_buz(m0));
            chk("dut0_busy", int'(busy0), (m0.st == 1 || m0.st == 2) ? 1 : 0);
            chk("dut0_flag", int'(flag0), (m0.st == 3) ? 1 : 0);
            chk("dut1_buzzer", int'(buz1), e_buz(m1));
            chk("dut1_busy", int'(busy1), (m1.st == 1 || m1.st == 2) ? 1 : 0);
            chk("dut1_flag", int'(flag1), (m1.st == 3) ? 1 : 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic meas(input int n, input bit sel, output int highs, output int rises);
        bit prev, cur;
        prev  = sel ? buz1 : buz0;
        highs = 0;
        rises = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            cur = sel ? buz1 : buz0;
            if (cur) highs++;
            if (cur && !prev) rises++;
            prev = cur;
        end
    endtask

    initial begin
        int h, r, h2, r2;
        reset = 1'b1;
        gate  = 1'b0;
        ten   = 1'b1;
        hp    = 16'd4;
        cyc(3);
        chk("reset_buzzer", int'(buz0), 0);
        chk("reset_busy", int'(busy0), 0);
        chk("reset_flag", int'(flag1), 0);
        reset = 1'b0;
        cyc(2);

        // Tone hp=4, gate high for 40 samples, falls at end of a low half.
        gate = 1'b1;
        cyc(1);
        chk("t1_latency1", int'(buz0), 1);
        meas(39, 1'b0, h, r);
        chk("t1_high_cycles", h, 19);
        chk("t1_rises", r, 4);
        gate = 1'b0;
        cyc(1);
        chk("t1_out_after_fall", int'(buz0), 0);
        chk("t1_busy_after_fall", int'(busy0), 0);
        cyc(3);

        // hp=5, gate dropped 2 cycles into the high half, re-raised during DRAIN.
        hp   = 16'd5;
        gate = 1'b1;
        meas(2, 1'b0, h, r);
        gate = 1'b0;
        meas(1, 1'b0, h2, r2);
        h += h2;
        gate = 1'b1;
        meas(2, 1'b0, h2, r2);
        h += h2;
        chk("t2_high_len", h, 5);
        cyc(1);
        chk("t2_idle_gap_out", int'(buz0), 0);
        chk("t2_idle_gap_busy", int'(busy0), 0);
        cyc(1);
        chk("t2_reassert", int'(buz0), 1);
        gate = 1'b0;
        cyc(8);

        // hp changed 4 -> 2 in the middle of the first high half.
        hp   = 16'd4;
        gate = 1'b1;
        cyc(2);
        hp = 16'd2;
        meas(12, 1'b0, h, r);
        chk("t3_high_cycles", h, 6);
        chk("t3_rises", r, 2);
        gate = 1'b0;
        cyc(4);

        // Watchdog: 20-cycle limit, hp=3, gate held 50 cycles.
        hp   = 16'd3;
        gate = 1'b1;
        meas(50, 1'b1, h, r);
        chk("t4_high_cycles", h, 12);
        chk("t4_rises", r, 4);
        chk("t4_flag_held", int'(flag1), 1);
        gate = 1'b0;
        cyc(1);
        chk("t4_flag_clear", int'(flag1), 0);
        chk("t4_busy_clear", int'(busy1), 0);
        cyc(4);

        // Gate fall on the very cycle the watchdog would expire: no lockout.
        gate = 1'b1;
        cyc(20);
        gate = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk("t4b_no_lockout", int'(flag1), 0);
        end
        cyc(2);

        // Pass-through; tone_en toggled while running must not change the output.
        ten  = 1'b0;
        hp   = 16'd1;
        gate = 1'b1;
        cyc(1);
        chk("t5_pass_high", int'(buz0), 1);
        ten = 1'b1;
        meas(6, 1'b0, h, r);
        chk("t5_pass_steady", h, 6);
        gate = 1'b0;
        cyc(1);
        chk("t5_pass_low", int'(buz0), 0);
        gate = 1'b1;
        cyc(1);
        chk("t5_pass_reraise", int'(buz0), 1);
        gate = 1'b0;
        cyc(3);

        // hp=0 behaves as 1; then reset mid-tone.
        hp   = 16'd0;
        gate = 1'b1;
        meas(8, 1'b0, h, r);
        chk("t6_hp0_highs", h, 4);
        chk("t6_hp0_rises", r, 4);
        reset = 1'b1;
        cyc(1);
        chk("t6_reset_buz0", int'(buz0), 0);
        chk("t6_reset_busy0", int'(busy0), 0);
        chk("t6_reset_buz1", int'(buz1), 0);
        chk("t6_reset_busy1", int'(busy1), 0);
        reset = 1'b0;
        gate  = 1'b0;
        cyc(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
